// File: rtl/dual_stepper_sequencer_if.sv
// Move-command handshake between the arm controller and the stepper sequencer.
// The controller drives a move and cmdValid; the sequencer answers with ready.
interface dual_stepper_sequencer_if;
    logic [7:0] steps1;
    logic [7:0] steps2;
    logic       dir1;
    logic       dir2;
    logic       cmdValid;
    logic       ready;

    modport master (
        output steps1, steps2, dir1, dir2, cmdValid,
        input  ready
    );

    modport slave (
        input  steps1, steps2, dir1, dir2, cmdValid,
        output ready
    );
endinterface

// File: rtl/dual_stepper_sequencer.sv
// Two-axis Bresenham step sequencer for the SCARA joint drivers.
// Both axes start and finish together; every output is registered.
module dual_stepper_sequencer #(
    parameter int STEP_PERIOD = 50000,
    parameter int PULSE_WIDTH = 100,
    parameter int DIR_SETUP   = 10
) (
    input  logic clk,
    input  logic reset,
    dual_stepper_sequencer_if.slave cmd,
    output logic step1Out,
    output logic step2Out,
    output logic dir1Out,
    output logic dir2Out,
    output logic busy,
    output logic moveDone
);

    localparam int PBITS = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam int SBITS = $clog2(DIR_SETUP + 1);
    localparam logic [PBITS-1:0] P_LAST = PBITS'(STEP_PERIOD - 1);
    localparam logic [PBITS-1:0] P_PW   = PBITS'(PULSE_WIDTH - 1);
    localparam logic [SBITS-1:0] S_INIT = SBITS'(DIR_SETUP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t           state;
    logic             rdy;
    logic             maj1;
    logic [7:0]       major;
    logic [7:0]       minor;
    logic [7:0]       ticks;
    logic [8:0]       acc;
    logic [PBITS-1:0] phase;
    logic [SBITS-1:0] scnt;

    logic       a1maj;
    logic [7:0] new_major;
    logic [7:0] new_minor;
    logic [8:0] acc_sum;
    logic       hit;
    logic       fire;

    assign cmd.ready = rdy;

    // Ties go to axis 1 as major.
    assign a1maj     = cmd.steps1 >= cmd.steps2;
    assign new_major = a1maj ? cmd.steps1 : cmd.steps2;
    assign new_minor = a1maj ? cmd.steps2 : cmd.steps1;

    // acc < major <= 255 and minor <= 255, so the sum fits 9 bits.
    assign acc_sum = acc + {1'b0, minor};
    assign hit     = acc_sum >= {1'b0, major};

    assign fire = (state == SETUP && scnt == '0) ||
                  (state == RUN && phase == P_LAST && ticks != 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rdy      <= 1'b1;
            busy     <= 1'b0;
            moveDone <= 1'b0;
            step1Out <= 1'b0;
            step2Out <= 1'b0;
            dir1Out  <= 1'b0;
            dir2Out  <= 1'b0;
            maj1     <= 1'b0;
            major    <= '0;
            minor    <= '0;
            ticks    <= '0;
            acc      <= '0;
            phase    <= '0;
            scnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd.cmdValid) begin
                        rdy     <= 1'b0;
                        busy    <= 1'b1;
                        dir1Out <= cmd.dir1;
                        dir2Out <= cmd.dir2;
                        maj1    <= a1maj;
                        major   <= new_major;
                        minor   <= new_minor;
                        ticks   <= new_major;
                        acc     <= {2'b00, new_major[7:1]};
                        phase   <= '0;
                        scnt    <= S_INIT;
                        if (new_major == 8'd0)
                            state <= DONE;
                        else
                            state <= SETUP;
                    end
                end
                SETUP: begin
                    if (scnt == '0)
                        state <= RUN;
                    else
                        scnt <= scnt - 1'b1;
                end
                RUN: begin
                    if (phase == P_LAST) begin
                        if (ticks == 8'd0) begin
                            state    <= DONE;
                            moveDone <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                        if (phase == P_PW) begin
                            step1Out <= 1'b0;
                            step2Out <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Zero-length moves arrive here with moveDone still low.
                    if (moveDone) begin
                        moveDone <= 1'b0;
                        rdy      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        moveDone <= 1'b1;
                    end
                end
            endcase

            if (fire) begin
                phase    <= '0;
                ticks    <= ticks - 8'd1;
                acc      <= hit ? acc_sum - {1'b0, major} : acc_sum;
                step1Out <= maj1 ? 1'b1 : hit;
                step2Out <= maj1 ? hit : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_stepper_sequencer.sv
// Directed bench for dual_stepper_sequencer (period 10, pulse 3, setup 2).
// Step edges and moveDone are timed against the accept edge.
module tb_dual_stepper_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic step1Out, step2Out, dir1Out, dir2Out, busy, moveDone;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    int r1[$];
    int r2[$];
    int w1[$];
    int w2[$];
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    int   h1 = 0;
    int   h2 = 0;
    int   mdn = 0;

    dual_stepper_sequencer_if cmd();

    dual_stepper_sequencer #(
        .STEP_PERIOD(10),
        .PULSE_WIDTH(3),
        .DIR_SETUP(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd(cmd),
        .step1Out(step1Out),
        .step2Out(step2Out),
        .dir1Out(dir1Out),
        .dir2Out(dir2Out),
        .busy(busy),
        .moveDone(moveDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
        if (step1Out && !p1) r1.push_back(cyc);
        if (!step1Out && p1) w1.push_back(h1);
        h1 = step1Out ? h1 + 1 : 0;
        p1 = step1Out;
        if (step2Out && !p2) r2.push_back(cyc);
        if (!step2Out && p2) w2.push_back(h2);
        h2 = step2Out ? h2 + 1 : 0;
        p2 = step2Out;
        if (moveDone) mdn++;
    endtask

    task automatic clear_mon();
        r1.delete();
        r2.delete();
        w1.delete();
        w2.delete();
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic da, input logic db,
                          input bit hold, output int t);
        int n = 0;
        while (!cmd.ready && n < 3000) begin
            nc();
            n++;
        end
        if (!cmd.ready) chk("launch_ready", 0, 1);
        cmd.steps1   = a;
        cmd.steps2   = b;
        cmd.dir1     = da;
        cmd.dir2     = db;
        cmd.cmdValid = 1'b1;
        nc();
        t = cyc;
        if (!hold) cmd.cmdValid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget,
                             output int md);
        int n = 0;
        md = -1;
        while (!moveDone && n < budget) begin
            nc();
            n++;
        end
        if (moveDone) md = cyc;
        else chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic chk_widths(input string tag);
        int bad = 0;
        foreach (w1[i]) if (w1[i] != 3) bad++;
        foreach (w2[i]) if (w2[i] != 3) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        int t, t2, md, same, mdn0;
        int exp2[4] = '{0, 20, 40, 60};

        reset        = 1'b1;
        cmd.steps1   = '0;
        cmd.steps2   = '0;
        cmd.dir1     = 1'b0;
        cmd.dir2     = 1'b0;
        cmd.cmdValid = 1'b0;
        repeat (3) nc();
        reset = 1'b0;
        nc();
        chk("rst_ready", int'(cmd.ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_step", int'({step1Out, step2Out}), 0);
        chk("rst_dir", int'({dir1Out, dir2Out}), 0);
        chk("rst_done", int'(moveDone), 0);

        // 8/4 move: timing of every edge
        clear_mon();
        launch(8'd8, 8'd4, 1'b1, 1'b0, 1'b0, t);
        chk("t1_ready_low", int'(cmd.ready), 0);
        chk("t1_busy", int'(busy), 1);
        chk("t1_dir1", int'(dir1Out), 1);
        chk("t1_dir2", int'(dir2Out), 0);
        wait_done("t1", 200, md);
        chk("t1_done_at", md - t, 82);
        nc();
        chk("t1_ready_at", int'(cmd.ready), 1);
        chk("t1_done_pulse", int'(moveDone), 0);
        chk("t1_n1", r1.size(), 8);
        chk("t1_n2", r2.size(), 4);
        foreach (r1[k]) chk($sformatf("t1_rise1_%0d", k), r1[k] - t, 2 + 10 * k);
        foreach (r2[k]) if (k < 4) chk($sformatf("t1_rise2_%0d", k), r2[k] - t, 2 + exp2[k]);
        chk_widths("t1_width");

        // zero-length move
        clear_mon();
        launch(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, t);
        chk("t2_ready_low", int'(cmd.ready), 0);
        chk("t2_dir2", int'(dir2Out), 1);
        wait_done("t2", 10, md);
        chk("t2_done_at", md - t, 1);
        nc();
        chk("t2_ready_at", int'(cmd.ready), 1);
        chk("t2_pulses", r1.size() + r2.size(), 0);

        // tie: both axes step together
        clear_mon();
        launch(8'd5, 8'd5, 1'b0, 1'b1, 1'b0, t);
        wait_done("t3a", 100, md);
        chk("t3a_done_at", md - t, 52);
        chk("t3a_n1", r1.size(), 5);
        chk("t3a_n2", r2.size(), 5);
        same = 0;
        foreach (r1[k]) if (k < r2.size() && r1[k] == r2[k]) same++;
        chk("t3a_together", same, 5);

        // axis 2 only
        clear_mon();
        launch(8'd0, 8'd200, 1'b1, 1'b1, 1'b0, t);
        wait_done("t3b", 2100, md);
        chk("t3b_done_at", md - t, 2002);
        chk("t3b_n1", r1.size(), 0);
        chk("t3b_n2", r2.size(), 200);

        // largest counts
        clear_mon();
        launch(8'd255, 8'd254, 1'b0, 1'b0, 1'b0, t);
        wait_done("t4", 2700, md);
        chk("t4_done_at", md - t, 2552);
        nc();
        chk("t4_ready_at", int'(cmd.ready), 1);
        chk("t4_n1", r1.size(), 255);
        chk("t4_n2", r2.size(), 254);

        // cmdValid held high with new values during a move
        clear_mon();
        launch(8'd3, 8'd1, 1'b1, 1'b1, 1'b1, t);
        cmd.steps1 = 8'd2;
        cmd.steps2 = 8'd2;
        cmd.dir1   = 1'b0;
        cmd.dir2   = 1'b0;
        wait_done("t5a", 60, md);
        chk("t5a_done_at", md - t, 32);
        chk("t5a_dirs_held", int'({dir1Out, dir2Out}), 3);
        chk("t5a_n1", r1.size(), 3);
        chk("t5a_n2", r2.size(), 1);
        nc();
        chk("t5_ready_up", int'(cmd.ready), 1);
        nc();
        t2 = cyc;
        cmd.cmdValid = 1'b0;
        chk("t5b_accept_at", t2 - t, 34);
        chk("t5b_ready_low", int'(cmd.ready), 0);
        chk("t5b_dirs", int'({dir1Out, dir2Out}), 0);
        clear_mon();
        wait_done("t5b", 60, md);
        chk("t5b_done_at", md - t2, 22);
        chk("t5b_n1", r1.size(), 2);
        chk("t5b_n2", r2.size(), 2);

        // reset during the third step pulse
        clear_mon();
        launch(8'd8, 8'd4, 1'b0, 1'b0, 1'b0, t);
        while (cyc < t + 23) nc();
        chk("t6_pulse_high", int'({step1Out, step2Out}), 3);
        mdn0 = mdn;
        reset = 1'b1;
        #1;
        chk("t6_pins_low", int'({step1Out, step2Out}), 0);
        chk("t6_ready_rst", int'(cmd.ready), 1);
        nc();
        nc();
        reset = 1'b0;
        repeat (100) nc();
        chk("t6_no_done", mdn - mdn0, 0);
        chk("t6_ready", int'(cmd.ready), 1);
        chk("t6_busy", int'(busy), 0);
        clear_mon();
        launch(8'd2, 8'd1, 1'b1, 1'b0, 1'b0, t);
        wait_done("t6b", 60, md);
        chk("t6b_done_at", md - t, 22);
        chk("t6b_n1", r1.size(), 2);
        chk("t6b_n2", r2.size(), 1);
        if (r1.size() > 0) chk("t6b_rise1", r1[0] - t, 2);
        if (r2.size() > 0) chk("t6b_rise2", r2[0] - t, 2);
        chk_widths("t6b_width");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
